// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
// Build option: define REGFILE_BYPASS_EN for same-cycle write-through forwarding.
// Contents:
//   clr_state_e     - bulk-clear FSM encoding (IDLE=0, CLEAR=1, DONE=2)
//   DefaultDataW/AW - default register width and address width
//   reg_writable()  - write-qualify for the hard-wired-zero register 0
package regfile_pkg;

  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultAddrW = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StDone  = 2'd2
  } clr_state_e;

  // Register 0 is read-only zero when zero_reg0 is set.
  function automatic logic reg_writable(input bit zero_reg0, input logic addr_is_zero);
    return !(zero_reg0 && addr_is_zero);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Core-side bus of the register file.
// Build option: REGFILE_BYPASS_EN affects only the slave's read behaviour.
// master: drives write port, read addresses, scoreboard set, clear request;
//         receives read data, scoreboard busy flags, clear status.
// slave:  the register file side of the same signals.
interface regfile_mp_if import regfile_pkg::*; #(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ADDR_W = DefaultAddrW
);
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              sb_set;
  logic [ADDR_W-1:0] sb_addr;
  logic              sb_busy1;
  logic              sb_busy2;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;

  modport master (
    output wen, waddr, wdata, raddr1, raddr2, sb_set, sb_addr, clr_req,
    input  rdata1, rdata2, sb_busy1, sb_busy2, clr_busy, clr_done
  );

  modport slave (
    input  wen, waddr, wdata, raddr1, raddr2, sb_set, sb_addr, clr_req,
    output rdata1, rdata2, sb_busy1, sb_busy2, clr_busy, clr_done
  );
endinterface

// File: rtl/regfile_clr_fsm.sv
// Sequential bulk-clear engine: walks every register index once, zeroing one per cycle.
// Build option: none (REGFILE_BYPASS_EN does not affect this block).
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   clr_req    - request to start a clear (honoured only in IDLE)
//   clr_start  - clr_req accepted this cycle (scoreboard flush strobe)
//   clr_en     - zero register clr_addr on this edge
//   clr_addr   - index being cleared
//   clr_busy   - engine active (CLEAR state)
//   clr_done   - one-cycle completion pulse (DONE state)
module regfile_clr_fsm import regfile_pkg::*; #(
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_start,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_busy,
  output logic              clr_done
);

  clr_state_e        state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;
  logic              done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (clr_req) begin
            state_q <= StClear;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StClear: begin
          // Terminal on all-ones; the counter holds rather than wrapping.
          if (cnt_q == '1) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: state_q <= StIdle;
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_start = clr_req && (state_q == StIdle);
  assign clr_en    = busy_q;
  assign clr_addr  = cnt_q;
  assign clr_busy  = busy_q;
  assign clr_done  = done_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: two combinational read ports, one synchronous write port,
// per-register pending-write scoreboard and a sequential bulk-clear engine.
// Build option: `define REGFILE_BYPASS_EN forwards an accepted write to matching read ports
// (and masks their scoreboard busy) in the same cycle.
// Ports:
//   clk - clock
//   rst - asynchronous active-low reset
//   bus - regfile_mp_if.slave (write, reads, scoreboard, clear control/status)
module regfile_mp import regfile_pkg::*; #(
  parameter int unsigned DATA_W    = DefaultDataW,
  parameter int unsigned ADDR_W    = DefaultAddrW,
  parameter bit          ZERO_REG0 = 1'b1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  sb_q, sb_d;

  logic              clr_start, clr_en, clr_busy, clr_done;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_accept, sb_accept;

  regfile_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk       (clk),
    .rst       (rst),
    .clr_req   (bus.clr_req),
    .clr_start (clr_start),
    .clr_en    (clr_en),
    .clr_addr  (clr_addr),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done)
  );

  assign bus.clr_busy = clr_busy;
  assign bus.clr_done = clr_done;

  // External writes and scoreboard sets are dropped while the clear engine runs.
  assign wr_accept = bus.wen && !clr_busy && reg_writable(ZERO_REG0, bus.waddr == '0);
  assign sb_accept = bus.sb_set && !clr_busy && reg_writable(ZERO_REG0, bus.sb_addr == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (clr_en) begin
      regs_q[clr_addr] <= '0;
    end else if (wr_accept) begin
      regs_q[bus.waddr] <= bus.wdata;
    end
  end

  // Set after clear so a same-address set keeps the newer producer outstanding.
  always_comb begin
    sb_d = sb_q;
    if (wr_accept) sb_d[bus.waddr] = 1'b0;
    if (sb_accept) sb_d[bus.sb_addr] = 1'b1;
    if (clr_start) sb_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  always_comb begin
    bus.rdata1   = regs_q[bus.raddr1];
    bus.rdata2   = regs_q[bus.raddr2];
    bus.sb_busy1 = sb_q[bus.raddr1];
    bus.sb_busy2 = sb_q[bus.raddr2];
    if (!reg_writable(ZERO_REG0, bus.raddr1 == '0)) bus.rdata1 = '0;
    if (!reg_writable(ZERO_REG0, bus.raddr2 == '0)) bus.rdata2 = '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_accept && (bus.raddr1 == bus.waddr)) begin
      bus.rdata1 = bus.wdata;
      if (!(sb_accept && (bus.sb_addr == bus.raddr1))) bus.sb_busy1 = 1'b0;
    end
    if (wr_accept && (bus.raddr2 == bus.waddr)) begin
      bus.rdata2 = bus.wdata;
      if (!(sb_accept && (bus.sb_addr == bus.raddr2))) bus.sb_busy2 = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (32 x 32, ZERO_REG0=1). Directed steps plus a
// randomized phase, all compared against an array-based reference model.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_mp #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .ZERO_REG0 (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_regs [DEPTH];
  logic        m_sb   [DEPTH];
  bit          in_clear = 1'b0;
  bit          exp_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (!in_clear && bus.wen && bus.waddr == a) return bus.wdata;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_sb(input logic [4:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (!in_clear && bus.wen && bus.waddr == a && !(bus.sb_set && bus.sb_addr == a))
      return 1'b0;
`endif
    return m_sb[a];
  endfunction

  task automatic check_ports(input string tag);
    check({tag, "_rdata1"}, bus.rdata1, exp_rd(bus.raddr1));
    check({tag, "_rdata2"}, bus.rdata2, exp_rd(bus.raddr2));
    check({tag, "_sb_busy1"}, {31'h0, bus.sb_busy1}, {31'h0, exp_sb(bus.raddr1)});
    check({tag, "_sb_busy2"}, {31'h0, bus.sb_busy2}, {31'h0, exp_sb(bus.raddr2)});
    check({tag, "_clr_busy"}, {31'h0, bus.clr_busy}, {31'h0, in_clear});
    check({tag, "_clr_done"}, {31'h0, bus.clr_done}, {31'h0, exp_done});
  endtask

  task automatic idle_inputs();
    bus.wen = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.raddr1 = '0; bus.raddr2 = '0;
    bus.sb_set = 1'b0; bus.sb_addr = '0; bus.clr_req = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = 32'h0;
      m_sb[i]   = 1'b0;
    end
  endtask

  // Apply the architectural effect of the current inputs, then advance one edge.
  task automatic tick();
    if (!in_clear) begin
      if (bus.wen && bus.waddr != 0) begin
        m_regs[bus.waddr] = bus.wdata;
        m_sb[bus.waddr]   = 1'b0;
      end
      if (bus.sb_set && bus.sb_addr != 0) m_sb[bus.sb_addr] = 1'b1;
      if (bus.clr_req) for (int i = 0; i < DEPTH; i++) m_sb[i] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    idle_inputs();
    bus.wen = 1'b1; bus.waddr = a; bus.wdata = d;
    tick();
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    model_reset();
    bus.raddr1 = 5'd5;
    #1;
    check_ports("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;

    // Asynchronous reset clears storage without any clock edge.
    write(5'd5, 32'hDEADBEEF);
    bus.raddr1 = 5'd5;
    #1;
    check_ports("wr_r5");
    check("r5_value", bus.rdata1, 32'hDEADBEEF);
    #1 rst = 1'b0;
    #1 model_reset();
    check("rst_async_rd1", bus.rdata1, 32'h0);
    check_ports("rst_async");
    @(posedge clk); #1;
    rst = 1'b1;

    // Write/read, both ports on one address.
    idle_inputs();
    bus.wen = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'h12345678;
    bus.raddr1 = 5'd3; bus.raddr2 = 5'd3;
    #1 check_ports("wr3_pre");
    tick();
    idle_inputs();
    bus.raddr1 = 5'd3; bus.raddr2 = 5'd3;
    #1 check_ports("wr3_post");
    check("wr3_const", bus.rdata2, 32'h12345678);
    write(5'd0, 32'hFFFFFFFF);
    #1 check_ports("r0");
    check("r0_const", bus.rdata1, 32'h0);

    // Scoreboard.
    bus.sb_set = 1'b1; bus.sb_addr = 5'd7;
    tick();
    idle_inputs();
    bus.raddr1 = 5'd7;
    #1 check_ports("sb7_set");
    check("sb7_const", {31'h0, bus.sb_busy1}, 32'h1);
    bus.wen = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h77;
    #1 check_ports("sb7_wr");
    tick();
    idle_inputs();
    bus.raddr1 = 5'd7;
    #1 check_ports("sb7_clr");
    check("sb7_clr_const", {31'h0, bus.sb_busy1}, 32'h0);
    bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    bus.wen = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h99;
    tick();
    idle_inputs();
    bus.raddr1 = 5'd9; bus.raddr2 = 5'd9;
    #1 check_ports("sb9");
    check("sb9_const", {31'h0, bus.sb_busy2}, 32'h1);
    bus.sb_set = 1'b1; bus.sb_addr = 5'd0;
    tick();
    idle_inputs();
    #1 check_ports("sb0");

    // Same-cycle forwarding (or not, without the option).
    write(5'd4, 32'h11111111);
    bus.wen = 1'b1; bus.waddr = 5'd4; bus.wdata = 32'hA5A5A5A5; bus.raddr1 = 5'd4;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_rd1", bus.rdata1, 32'hA5A5A5A5);
`else
    check("bypass_rd1", bus.rdata1, 32'h11111111);
`endif
    check_ports("bypass");
    tick();
    idle_inputs();

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      bus.wen     = 1'($urandom_range(0, 1));
      bus.waddr   = 5'($urandom_range(0, 31));
      bus.wdata   = $urandom;
      bus.raddr1  = 5'($urandom_range(0, 31));
      bus.raddr2  = (n % 4 == 0) ? bus.waddr : 5'($urandom_range(0, 31));
      bus.sb_set  = 1'($urandom_range(0, 1));
      bus.sb_addr = (n % 5 == 0) ? bus.waddr : 5'($urandom_range(0, 31));
      #1 check_ports("rand");
      tick();
    end
    idle_inputs();

    // Bulk clear, with a write accepted on the request edge.
    for (int i = 1; i < DEPTH; i++) write(5'(i), 32'(i));
    bus.sb_set = 1'b1; bus.sb_addr = 5'd7;
    tick();
    idle_inputs();
    bus.clr_req = 1'b1;
    bus.wen = 1'b1; bus.waddr = 5'd31; bus.wdata = 32'h55;
    bus.raddr1 = 5'd7;
    #1 check_ports("clr_req");
    tick();
    idle_inputs();
    in_clear = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.raddr1 = 5'(i);
      bus.raddr2 = 5'((i + 31) % 32);
      if (i == 5) begin bus.wen = 1'b1; bus.waddr = 5'd2; bus.wdata = 32'hDEAD; end
      if (i == 6) begin bus.sb_set = 1'b1; bus.sb_addr = 5'd3; end
      if (i == 7) bus.clr_req = 1'b1;
      #1 check_ports("clr_cyc");
      check("clr_busy_const", {31'h0, bus.clr_busy}, 32'h1);
      tick();
      m_regs[i] = 32'h0;
      idle_inputs();
    end
    in_clear = 1'b0;
    exp_done = 1'b1;
    #1 check_ports("clr_done");
    check("clr_done_const", {31'h0, bus.clr_done}, 32'h1);
    tick();
    exp_done = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.raddr1 = 5'(i);
      bus.raddr2 = 5'(31 - i);
      #1 check("clr_zero_rd1", bus.rdata1, 32'h0);
      check_ports("clr_after");
    end

    // Reset in the middle of a clear.
    for (int i = 1; i <= 12; i++) write(5'(i), 32'(i * 3));
    bus.clr_req = 1'b1;
    tick();
    idle_inputs();
    in_clear = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.raddr1 = 5'(i + 1);
      #1 check_ports("mid_clr");
      tick();
      m_regs[i] = 32'h0;
    end
    #1 rst = 1'b0;
    #1 model_reset();
    in_clear = 1'b0;
    check_ports("rst_mid");
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 check_ports("post_rst");
      tick();
    end
    for (int i = 0; i < DEPTH; i++) begin
      bus.raddr1 = 5'(i);
      bus.raddr2 = 5'(i);
      #1 check_ports("rst_zero");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor of the 32x32 CPU register file; sits in the decode stage of the core.
- Provides two asynchronous read ports and one synchronous write port, with configurable width and depth.
- Adds a per-register pending-write scoreboard for hazard detection.
- Adds a sequential bulk-clear engine, so the core can zero the file without asserting reset.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG0, 1, when 1 register 0 reads as zero and ignores writes.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wen  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- raddr1  in  ADDR_W  read address, port 1.
- raddr2  in  ADDR_W  read address, port 2.
- rdata1  out  DATA_W  read data, port 1 (combinational).
- rdata2  out  DATA_W  read data, port 2 (combinational).
- sb_set  in  1  mark register sb_addr as pending a write.
- sb_addr  in  ADDR_W  scoreboard set address.
- sb_busy1  out  1  register raddr1 is pending (combinational).
- sb_busy2  out  1  register raddr2 is pending (combinational).
- clr_req  in  1  single-cycle request to zero the whole file.
- clr_busy  out  1  clear engine active.
- clr_done  out  1  one-cycle pulse when clear completes.

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers = 0; scoreboard = 0; FSM = IDLE; clr_busy = 0; clr_done = 0.
  - rdata1/rdata2 therefore read 0.
  - Reset mid-clear aborts the clear immediately.
- Reads:
  - combinational; rdataN = reg[raddrN].
  - With ZERO_REG0=1, address 0 always returns 0.
  - The two ports are fully independent; the same address on both ports is legal.
- Writes:
  - rising edge; reg[waddr] <= wdata when wen=1, FSM=IDLE, and not (ZERO_REG0 and waddr=0).
  - Write latency 1 cycle (see optional feature for same-cycle visibility).
- Scoreboard (DEPTH bits):
  - sb_set sets bit[sb_addr].
  - An accepted write clears bit[waddr].
  - sb_set and write to the same address in the same cycle: set wins, bit stays 1 (the newer producer is outstanding).
  - With ZERO_REG0=1, bit 0 is never set.
  - sb_busyN = bit[raddrN].
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE: clr_req=1 -> CLEAR; counter <= 0; scoreboard cleared on the same edge.
  - CLEAR: each cycle reg[counter] <= 0 and counter increments. At counter = DEPTH-1 -> DONE.
    - Total DEPTH cycles in CLEAR; clr_busy = 1.
    - External wen and sb_set are dropped; reads return current, partially cleared contents.
    - clr_req is ignored.
  - DONE: clr_done = 1 for exactly one cycle, clr_busy = 0 -> IDLE.
    - Writes are accepted again in DONE.
  - The counter is ADDR_W bits wide; terminal detection is on the all-ones value, with no wrap past it.
- Simultaneous clr_req and wen in IDLE: the write is accepted on that edge, then overwritten when its index is cleared.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - write-through forwarding; if wen=1, FSM=IDLE, and raddrN == waddr (nonzero when ZERO_REG0), rdataN = wdata in the same cycle.
  - sb_busyN is also forced to 0 for that address, unless sb_set targets it in the same cycle.
- Undefined:
  - reads return the pre-write contents until the next cycle.
  - sb_busyN reflects stored bits only.

Decomposition:
- Package regfile_pkg holds:
  - FSM state encoding: IDLE=2'd0, CLEAR=2'd1, DONE=2'd2.
  - Default width/depth constants.
  - A function for the ZERO_REG0 write-qualify logic.
- One natural sub-module: regfile_clr_fsm (state register, counter, clr_busy/clr_done, clear-address/enable outputs).
- Storage, read muxing and scoreboard stay in the top.

Test Plan:
- Reset: write 0xDEADBEEF to r5, pulse rst=0 mid-cycle -> rdata1(raddr1=5) = 0 immediately, with no clock edge.
- Write/read: wen, waddr=3, wdata=0x12345678 -> next cycle rdata1 = rdata2 = 0x12345678 (raddr1 = raddr2 = 3). Write to r0 -> r0 still reads 0.
- Scoreboard: sb_set r7 -> sb_busy1 = 1 for raddr1=7. Write r7 -> cleared next cycle. Same-cycle sb_set r9 plus write r9 -> sb_busy stays 1.
- Clear: fill r1..r31 with their index, pulse clr_req -> clr_busy = 1 for 32 cycles, clr_done pulses in cycle 33, all registers read 0. A write issued during CLEAR is dropped.
- Reset mid-clear: assert rst at clear cycle 10 -> FSM IDLE, clr_busy = 0, no clr_done, all registers 0.
- Bypass (REGFILE_BYPASS_EN): wen, waddr=4, wdata=0xA5A5A5A5, raddr1=4 -> rdata1 = 0xA5A5A5A5 in the same cycle. Without the macro -> old value.
